// File: rtl/round_sat_pipe_if.sv
// round_sat_pipe_if
//   Streaming bundle for the requantiser: the wide input beat (valid/ready,
//   rounding mode, packed lanes) and the narrow output beat (valid/ready,
//   packed lanes, per-lane clamp flags).
//   Modports:
//     slave  - the requantiser's view (consumes din, produces dout)
//     master - the upstream/downstream environment's view
//   Parameters: WI input lane width, WO output lane width, NCH lane count.
interface round_sat_pipe_if #(
  parameter int WI  = 31,
  parameter int WO  = 10,
  parameter int NCH = 2
);
  logic               in_vld;
  logic               in_rdy;
  logic [1:0]         mode;
  logic [NCH*WI-1:0]  din;
  logic               out_vld;
  logic               out_rdy;
  logic [NCH*WO-1:0]  dout;
  logic [NCH-1:0]     out_sat;

  modport slave (
    input  in_vld, mode, din, out_rdy,
    output in_rdy, out_vld, dout, out_sat
  );

  modport master (
    output in_vld, mode, din, out_rdy,
    input  in_rdy, out_vld, dout, out_sat
  );
endinterface

// File: rtl/round_sat_pipe.sv
// round_sat_pipe
//   Multi-lane two-stage requantiser. Each signed WI-bit lane loses its
//   D = WI-WO LSBs under a per-beat rounding mode, then is clamped to WO bits.
//   Stage 1 registers the rounded sum (WO+1 bits, so it cannot wrap), stage 2
//   clamps and registers the output beat. Both stages advance together
//   whenever the output slot is empty or being drained.
//   Optional feature macro: ROUND_SAT_CNT_EN (saturation event counter).
//   Without it sat_cnt is tied to zero and no counter flops exist.
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous reset, active high
//   bus        round_sat_pipe_if.slave (in_vld/in_rdy/mode/din,
//              out_vld/out_rdy/dout/out_sat)
//   i_clr      clears sticky flags and event counter
//   o_sat_stk  per-lane sticky OR of out_sat over accepted output beats
//   o_sat_cnt  number of accepted output beats with any lane clamped
module round_sat_pipe #(
  parameter int WI      = 31,
  parameter int WO      = 10,
  parameter int NCH     = 2,
  parameter int SYM_SAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  round_sat_pipe_if.slave   bus,
  input  logic              i_clr,
  output logic [NCH-1:0]    o_sat_stk,
  output logic [CNT_W-1:0]  o_sat_cnt
);

  localparam int D = WI - WO;

  localparam logic [1:0] M_TRUNC = 2'd0;
  localparam logic [1:0] M_AWAY  = 2'd1;
  localparam logic [1:0] M_EVEN  = 2'd2;
  localparam logic [1:0] M_UP    = 2'd3;

  // Clamp limits in the WO+1 bit sum domain and in the WO bit output domain.
  localparam logic [WO:0]   C_MAX      = {2'b00, {(WO-1){1'b1}}};
  localparam logic [WO:0]   C_MIN      = {2'b11, {(WO-1){1'b0}}};
  localparam logic [WO-1:0] C_OUT_MAX  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] C_OUT_NSYM = {1'b1, {(WO-2){1'b0}}, 1'b1};

  logic           w_en;
  logic           r_s1_vld;
  logic           r_out_vld;
  logic [NCH-1:0] w_sat_all;
  logic           w_hs;
  logic           w_any_sat;

  assign w_en        = ~r_out_vld | bus.out_rdy;
  assign bus.in_rdy  = w_en;
  assign bus.out_vld = r_out_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_en) begin
      r_s1_vld  <= bus.in_vld;
      r_out_vld <= r_s1_vld;
    end
  end

  genvar k;
  for (k = 0; k < NCH; k++) begin : g_lane
    logic [WI-1:0] w_x;
    logic [WO-1:0] w_q;
    logic          w_h;
    logic          w_r;
    logic          w_s;
    logic          w_inc;
    logic [WO:0]   w_sum;
    logic [WO:0]   r_sum;
    logic          w_pos_ovf;
    logic          w_neg_ovf;
    logic [WO-1:0] w_dout_nxt;
    logic          w_sat_nxt;
    logic [WO-1:0] r_dout;
    logic          r_sat;

    assign w_x = bus.din[k*WI +: WI];
    // Upper WO bits are exactly the floor of din / 2^D in two's complement.
    assign w_q = w_x[WI-1:D];
    assign w_h = w_x[D-1];
    assign w_r = |w_x[D-2:0];
    assign w_s = w_x[WI-1];

    always_comb begin
      w_inc = 1'b0;
      case (bus.mode)
        M_TRUNC: w_inc = 1'b0;
        M_AWAY:  w_inc = w_h & (w_r | ~w_s);
        M_EVEN:  w_inc = w_h & (w_r | w_q[0]);
        M_UP:    w_inc = w_h;
        default: w_inc = 1'b0;
      endcase
    end

    assign w_sum = {w_q[WO-1], w_q} + {{WO{1'b0}}, w_inc};

    // The sum only exceeds the positive limit by rounding up from the top
    // code; the negative limit is reached only by the most negative code.
    assign w_pos_ovf = $signed(r_sum) > $signed(C_MAX);
    assign w_neg_ovf = (SYM_SAT != 0) && (r_sum == C_MIN);

    always_comb begin
      w_dout_nxt = r_sum[WO-1:0];
      w_sat_nxt  = 1'b0;
      if (w_pos_ovf) begin
        w_dout_nxt = C_OUT_MAX;
        w_sat_nxt  = 1'b1;
      end else if (w_neg_ovf) begin
        w_dout_nxt = C_OUT_NSYM;
        w_sat_nxt  = 1'b1;
      end
    end

    // Data registers load only with a valid beat so bubbles leave dout as-is.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sum  <= '0;
        r_dout <= '0;
        r_sat  <= 1'b0;
      end else if (w_en) begin
        if (bus.in_vld) r_sum <= w_sum;
        if (r_s1_vld) begin
          r_dout <= w_dout_nxt;
          r_sat  <= w_sat_nxt;
        end
      end
    end

    assign bus.dout[k*WO +: WO] = r_dout;
    assign w_sat_all[k]         = r_sat;
  end

  assign bus.out_sat = w_sat_all;
  assign w_hs        = r_out_vld & bus.out_rdy;
  assign w_any_sat   = |w_sat_all;

  logic [NCH-1:0] r_sat_stk;

  // A handshake in the same cycle as clr is recorded after the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sat_stk <= '0;
    end else if (i_clr) begin
      r_sat_stk <= w_hs ? w_sat_all : '0;
    end else if (w_hs) begin
      r_sat_stk <= r_sat_stk | w_sat_all;
    end
  end

  assign o_sat_stk = r_sat_stk;

`ifdef ROUND_SAT_CNT_EN
  logic [CNT_W-1:0] r_sat_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sat_cnt <= '0;
    end else if (i_clr) begin
      r_sat_cnt <= (w_hs & w_any_sat) ? CNT_W'(1) : '0;
    end else if (w_hs & w_any_sat & ~(&r_sat_cnt)) begin
      r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign o_sat_cnt = r_sat_cnt;
`else
  assign o_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_round_sat_pipe.sv
module tb_round_sat_pipe;
  localparam int WI    = 8;
  localparam int WO    = 4;
  localparam int NCH   = 2;
  localparam int CNT_W = 16;
  localparam int D     = WI - WO;
`ifdef ROUND_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NCH*WO-1:0] d1;
    logic [NCH-1:0]    s1;
    logic [NCH*WO-1:0] d0;
    logic [NCH-1:0]    s0;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              in_vld = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [NCH*WI-1:0] din = '0;
  logic              out_rdy = 1'b1;
  logic [NCH-1:0]    stk1, stk0;
  logic [CNT_W-1:0]  cnt1, cnt0;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit started = 1'b0;

  exp_t           q[$];
  logic [NCH-1:0] m_stk1 = '0, m_stk0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0, m_cnt0 = '0;

  round_sat_pipe_if #(.WI(WI), .WO(WO), .NCH(NCH)) bus1 ();
  round_sat_pipe_if #(.WI(WI), .WO(WO), .NCH(NCH)) bus0 ();

  assign bus1.in_vld  = in_vld;
  assign bus1.mode    = mode;
  assign bus1.din     = din;
  assign bus1.out_rdy = out_rdy;
  assign bus0.in_vld  = in_vld;
  assign bus0.mode    = mode;
  assign bus0.din     = din;
  assign bus0.out_rdy = out_rdy;

  round_sat_pipe #(.WI(WI), .WO(WO), .NCH(NCH), .SYM_SAT(1), .CNT_W(CNT_W)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus1.slave), .i_clr(clr),
    .o_sat_stk(stk1), .o_sat_cnt(cnt1)
  );

  round_sat_pipe #(.WI(WI), .WO(WO), .NCH(NCH), .SYM_SAT(0), .CNT_W(CNT_W)) u_dut_asym (
    .i_clk(clk), .i_rst(rst), .bus(bus0.slave), .i_clr(clr),
    .o_sat_stk(stk0), .o_sat_cnt(cnt0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference rounding on plain integers: floor, fractional remainder, tie rules.
  function automatic logic [WO:0] model_lane(input logic [WI-1:0] x, input logic [1:0] m,
                                             input bit sym);
    int v, fl, frac, half, r, mx, mn;
    logic [WO:0] res;
    v    = int'($signed(x));
    fl   = v >>> D;
    frac = v - fl * (1 << D);
    half = 1 << (D - 1);
    case (m)
      2'd0:    r = fl;
      2'd1:    r = (frac > half || (frac == half && v >= 0)) ? fl + 1 : fl;
      2'd2:    r = (frac > half || (frac == half && (fl % 2) != 0)) ? fl + 1 : fl;
      default: r = (frac >= half) ? fl + 1 : fl;
    endcase
    mx = (1 << (WO - 1)) - 1;
    mn = sym ? -mx : -mx - 1;
    if (r > mx)      res = {1'b1, mx[WO-1:0]};
    else if (r < mn) res = {1'b1, mn[WO-1:0]};
    else             res = {1'b0, r[WO-1:0]};
    return res;
  endfunction

  function automatic exp_t build(input logic [NCH*WI-1:0] x, input logic [1:0] m);
    exp_t e;
    logic [WO:0] r;
    e = '0;
    for (int k = 0; k < NCH; k++) begin
      r = model_lane(x[k*WI +: WI], m, 1'b1);
      e.d1[k*WO +: WO] = r[WO-1:0];
      e.s1[k] = r[WO];
      r = model_lane(x[k*WI +: WI], m, 1'b0);
      e.d0[k*WO +: WO] = r[WO-1:0];
      e.s0[k] = r[WO];
    end
    return e;
  endfunction

  // Model update at each rising edge, from pre-edge values.
  always @(posedge clk) begin
    exp_t e;
    bit   hs;
    if (rst) begin
      q.delete();
      m_stk1 = '0; m_stk0 = '0; m_cnt1 = '0; m_cnt0 = '0;
      started = 1'b1;
    end else begin
      hs = (bus1.out_vld === 1'b1) && out_rdy && (q.size() != 0);
      e  = '0;
      if (hs) begin
        e = q.pop_front();
        delivered++;
      end
      if (clr) begin
        m_stk1 = hs ? e.s1 : '0;
        m_stk0 = hs ? e.s0 : '0;
        m_cnt1 = (CNT_EN && hs && |e.s1) ? CNT_W'(1) : '0;
        m_cnt0 = (CNT_EN && hs && |e.s0) ? CNT_W'(1) : '0;
      end else if (hs) begin
        m_stk1 = m_stk1 | e.s1;
        m_stk0 = m_stk0 | e.s0;
        if (CNT_EN && |e.s1 && m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
        if (CNT_EN && |e.s0 && m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
      end
      if (in_vld && bus1.in_rdy === 1'b1) q.push_back(build(din, mode));
    end
  end

  // Output and status comparison on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("stk1", stk1, m_stk1);
      chk("stk0", stk0, m_stk0);
      chk("cnt1", cnt1, m_cnt1);
      chk("cnt0", cnt0, m_cnt0);
      chk("vld_pair", bus0.out_vld, bus1.out_vld);
      if (bus1.out_vld === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_beat", bus1.out_vld, 1'b0);
        end else begin
          chk("dout1", bus1.dout, q[0].d1);
          chk("sat1", bus1.out_sat, q[0].s1);
          chk("dout0", bus0.dout, q[0].d0);
          chk("sat0", bus0.out_sat, q[0].s0);
        end
      end else begin
        chk("vld_known", bus1.out_vld, 1'b0);
      end
    end
  end

  task automatic drain(input string nm);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk(nm, q.size(), 0);
    @(negedge clk);
  endtask

  // Single beat into an empty pipe, with literal expected results and latency.
  task automatic beat_lit(input string nm, input logic [15:0] x, input logic [1:0] m,
                          input logic [7:0] e1, input logic [1:0] se1,
                          input logic [7:0] e0, input logic [1:0] se0);
    in_vld = 1'b1; din = x; mode = m; out_rdy = 1'b1;
    #1 chk({nm, "_in_rdy"}, bus1.in_rdy, 1'b1);
    @(negedge clk);
    in_vld = 1'b0; din = $urandom; mode = ~m;
    chk({nm, "_lat1"}, bus1.out_vld, 1'b0);
    @(negedge clk);
    chk({nm, "_lat2"}, bus1.out_vld, 1'b1);
    chk({nm, "_d1"}, bus1.dout, e1);
    chk({nm, "_s1"}, bus1.out_sat, se1);
    chk({nm, "_d0"}, bus0.dout, e0);
    chk({nm, "_s0"}, bus0.out_sat, se0);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int sent, d0, stall_seen;
    logic [7:0] lane;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_vld", bus1.out_vld, 1'b0);
    chk("rst_dout", bus1.dout, 8'h00);
    chk("rst_sat", bus1.out_sat, 2'b00);
    chk("rst_stk", stk1, 2'b00);
    chk("rst_cnt", cnt1, 16'h0000);
    chk("rst_in_rdy", bus1.in_rdy, 1'b1);

    beat_lit("m0_1p5",   16'h0018, 2'd0, 8'h01, 2'b00, 8'h01, 2'b00);
    beat_lit("m1_2p5",   16'h2818, 2'd1, 8'h32, 2'b00, 8'h32, 2'b00);
    beat_lit("m2_tie",   16'h2818, 2'd2, 8'h22, 2'b00, 8'h22, 2'b00);
    beat_lit("m3_neg",   16'hE818, 2'd3, 8'hF2, 2'b00, 8'hF2, 2'b00);
    beat_lit("m0_neg",   16'hE8E8, 2'd0, 8'hEE, 2'b00, 8'hEE, 2'b00);
    beat_lit("m1_neg",   16'hE818, 2'd1, 8'hE2, 2'b00, 8'hE2, 2'b00);
    beat_lit("m2_odd",   16'h3808, 2'd2, 8'h40, 2'b00, 8'h40, 2'b00);
    beat_lit("clamp_hi", 16'h7F18, 2'd1, 8'h72, 2'b10, 8'h72, 2'b10);
    beat_lit("clamp_lo", 16'h1080, 2'd0, 8'h19, 2'b01, 8'h18, 2'b00);
    beat_lit("m3_edge",  16'h7888, 2'd3, 8'h79, 2'b10, 8'h79, 2'b10);
    beat_lit("m1_lo",    16'h0087, 2'd1, 8'h09, 2'b01, 8'h08, 2'b00);

    sent = 0; d0 = delivered; stall_seen = 0;
    for (int c = 0; c < 40 && (sent < 6 || q.size() != 0); c++) begin
      out_rdy = !(c >= 3 && c < 6);
      in_vld  = (sent < 6);
      din     = $urandom;
      mode    = 2'($urandom_range(0, 3));
      #1;
      if (!out_rdy && bus1.out_vld === 1'b1) begin
        stall_seen++;
        chk("bp_in_rdy", bus1.in_rdy, 1'b0);
      end
      if (in_vld && bus1.in_rdy === 1'b1) sent++;
      @(negedge clk);
    end
    chk("bp_stalled", stall_seen, 3);
    chk("bp_delivered", delivered - d0, 6);
    drain("bp_drain");

    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_stk", stk1, 2'b00);
    chk("clr_cnt", cnt1, 16'h0000);
    in_vld = 1'b1; din = 16'h7F7F; mode = 2'd1;
    repeat (3) @(negedge clk);
    drain("st3_drain");
    chk("st3_cnt", cnt1, CNT_EN ? 32'd3 : 32'd0);
    chk("st3_stk", stk1, 2'b11);
    in_vld = 1'b1; din = 16'h7F00; mode = 2'd1;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    chk("clrev_vld", bus1.out_vld, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrev_cnt", cnt1, CNT_EN ? 32'd1 : 32'd0);
    chk("clrev_stk", stk1, 2'b10);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr2_stk", stk1, 2'b00);
    chk("clr2_cnt", cnt1, 16'h0000);
    in_vld = 1'b1; din = 16'h7F7F; mode = 2'd1;
    repeat (65540) @(negedge clk);
    drain("cntsat_drain");
    chk("cntsat_cnt", cnt1, CNT_EN ? 32'hFFFF : 32'd0);
    chk("cntsat_stk", stk1, 2'b11);

    for (int c = 0; c < 3000; c++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      mode    = 2'($urandom_range(0, 3));
      clr     = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < NCH; k++) begin
        lane = 8'($urandom);
        if ($urandom_range(0, 1) == 1) lane[3:0] = 4'h8;
        din[k*WI +: WI] = lane;
      end
      @(negedge clk);
    end
    clr = 1'b0;
    drain("rnd_drain");

    in_vld = 1'b1; din = 16'h3030; mode = 2'd0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    in_vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_vld", bus1.out_vld, 1'b0);
    repeat (6) @(negedge clk);
    chk("rstmid_q", q.size(), 0);
    chk("rstmid_vld2", bus1.out_vld, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
